// File: rtl/centroid_pkg.sv
// Shared types and derived constants for the thresholded-pixel centroid path.
// Contents: FSM state encoding, default geometry/width parameters, derived
// frame size and divider latency, and a latency helper for sibling blocks.
package centroid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_X   = 2'd1,
        ST_DIV_Y   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    localparam int unsigned DEF_IMG_W      = 640;
    localparam int unsigned DEF_IMG_H      = 480;
    localparam int unsigned DEF_COLOR_W    = 12;
    localparam int unsigned DEF_THRESH     = 'h700;
    localparam int unsigned DEF_MIN_PIXELS = 16;
    localparam int unsigned DEF_ACC_W      = 28;
    localparam int unsigned DEF_CNT_W      = 19;

    // Centroid coordinate width on the output bus.
    localparam int unsigned OUT_W = 11;

    localparam int unsigned FRAME_PIX = DEF_IMG_W * DEF_IMG_H;
    localparam int unsigned DIV_LAT   = DEF_ACC_W + 1;

    // Start-to-done latency of seq_divider for a given dividend width.
    function automatic int unsigned div_latency(input int unsigned acc_w);
        return acc_w + 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports: iCLK clock; iRST sync active-low reset; start sampled for one cycle;
// dividend (N bits) / divisor (D bits, nonzero); quotient (N bits, truncating);
// done pulses exactly N+1 cycles after the start cycle.
module seq_divider #(
    parameter int unsigned N = 28,
    parameter int unsigned D = 19
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         done
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [D-1:0]  rem;
    logic [CW-1:0] steps;
    logic          busy;
    logic [D:0]    trial;
    logic          ge;
    logic [D-1:0]  rem_nxt;

    // Shift next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial   = {rem, quotient[N-1]};
        ge      = (trial >= {1'b0, divisor});
        rem_nxt = ge ? D'(trial - {1'b0, divisor}) : trial[D-1:0];
    end

    // Iteration state; the quotient register doubles as the dividend shifter.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            rem      <= '0;
            quotient <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                quotient <= dividend;
                steps    <= CW'(N);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= rem_nxt;
                quotient <= {quotient[N-2:0], ge};
                steps    <= steps - CW'(1);
                if (steps == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/centroid_frame_ctrl.sv
// Frame-level centroid controller: raster tracking, thresholded X/Y/count
// accumulation, end-of-frame snapshot and two sequential divides (X then Y).
// Ports: iCLK clock; iRST sync active-low reset; iColor pixel intensity;
// iDVAL pixel valid; iFVAL frame valid (low aborts the frame);
// oX/oY centroid; oFound enough hits in last frame; oDVAL one-cycle result
// pulse; oBusy FSM not idle; oOverrun one-cycle pulse on a dropped frame end.
module centroid_frame_ctrl
    import centroid_pkg::*;
#(
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned COLOR_W    = DEF_COLOR_W,
    parameter int unsigned THRESH     = DEF_THRESH,
    parameter int unsigned MIN_PIXELS = DEF_MIN_PIXELS,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iColor,
    input  logic               iDVAL,
    input  logic               iFVAL,
    output logic [OUT_W-1:0]   oX,
    output logic [OUT_W-1:0]   oY,
    output logic               oFound,
    output logic               oDVAL,
    output logic               oBusy,
    output logic               oOverrun
);

    localparam int unsigned X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t             state;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [ACC_W-1:0]   sum_x;
    logic [ACC_W-1:0]   sum_y;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   snap_x;
    logic [ACC_W-1:0]   snap_y;
    logic [CNT_W-1:0]   snap_cnt;
    logic [OUT_W-1:0]   qx;

    logic               pix;
    logic               hit;
    logic               x_last;
    logic               y_last;
    logic               fe;
    logic [ACC_W-1:0]   sum_x_nxt;
    logic [ACC_W-1:0]   sum_y_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic               div_start;
    logic [ACC_W-1:0]   div_dividend;
    logic [ACC_W-1:0]   div_quotient;
    logic               div_done;
    logic               unused_q_hi;

    // Per-pixel qualifiers and accumulator values including the current pixel.
    always_comb begin
        pix       = iDVAL & iFVAL;
        hit       = pix && (iColor > COLOR_W'(THRESH));
        x_last    = (x == X_W'(IMG_W - 1));
        y_last    = (y == Y_W'(IMG_H - 1));
        fe        = pix & x_last & y_last;
        sum_x_nxt = sum_x + (hit ? ACC_W'(x) : '0);
        sum_y_nxt = sum_y + (hit ? ACC_W'(y) : '0);
        cnt_nxt   = cnt + (hit ? CNT_W'(1) : '0);
    end

    // Raster position and live accumulators; frame-valid low resynchronises.
    always_ff @(posedge iCLK) begin
        if (!iRST || !iFVAL) begin
            x     <= '0;
            y     <= '0;
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (pix) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
            if (fe) begin
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
            end else begin
                sum_x <= sum_x_nxt;
                sum_y <= sum_y_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    // Result sequencer: snapshot, divide X, divide Y, publish.
    // Outputs are loaded on entry to PUBLISH so oDVAL lines up with that state.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state     <= ST_IDLE;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_cnt  <= '0;
            qx        <= '0;
            div_start <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oFound    <= 1'b0;
            oDVAL     <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            div_start <= 1'b0;
            oDVAL     <= 1'b0;
            oOverrun  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fe) begin
                        snap_x   <= sum_x_nxt;
                        snap_y   <= sum_y_nxt;
                        snap_cnt <= cnt_nxt;
                        oBusy    <= 1'b1;
                        if (cnt_nxt >= CNT_W'(MIN_PIXELS)) begin
                            state     <= ST_DIV_X;
                            div_start <= 1'b1;
                        end else begin
                            state  <= ST_PUBLISH;
                            oFound <= 1'b0;
                            oDVAL  <= 1'b1;
                        end
                    end
                end
                ST_DIV_X: begin
                    if (div_done) begin
                        qx        <= div_quotient[OUT_W-1:0];
                        div_start <= 1'b1;
                        state     <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done) begin
                        oX     <= qx;
                        oY     <= div_quotient[OUT_W-1:0];
                        oFound <= 1'b1;
                        oDVAL  <= 1'b1;
                        state  <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    state <= ST_IDLE;
                    oBusy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    oBusy <= 1'b0;
                end
            endcase
            // A frame end while busy (including PUBLISH) is dropped.
            if (fe && (state != ST_IDLE)) begin
                oOverrun <= 1'b1;
            end
        end
    end

    assign div_dividend = (state == ST_DIV_Y) ? snap_y : snap_x;

    // Quotient MSBs are zero whenever the accumulator widths are valid.
    assign unused_q_hi = ^div_quotient[ACC_W-1:OUT_W];

    seq_divider #(
        .N (ACC_W),
        .D (CNT_W)
    ) u_div (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (snap_cnt),
        .quotient (div_quotient),
        .done     (div_done)
    );

endmodule

// File: tb/tb_centroid_frame_ctrl.sv
// Self-checking bench for centroid_frame_ctrl: a 16x8 instance driven from a
// vector table, and a 4x2 instance for overrun and mid-divide reset cases.
module tb_centroid_frame_ctrl;

    localparam int W1   = 16;
    localparam int H1   = 8;
    localparam int W2   = 4;
    localparam int H2   = 2;
    localparam int HI   = 'hFFF;
    localparam int DARK = 'h100;
    localparam int NV   = 6;

    logic        clk = 1'b0;
    logic        rst1, rst2;
    logic [11:0] col1, col2;
    logic        dv1, fv1, dv2, fv2;
    logic [10:0] x1, y1, x2, y2;
    logic        found1, dval1, busy1, ovr1;
    logic        found2, dval2, busy2, ovr2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dcnt1  = 0;
    int dcnt2  = 0;
    int img [W1*H1];

    typedef struct {
        int n;
        int h0, h1, h2, h3;
        int ex, ey, ef, elat;
    } vec_t;

    vec_t vecs [NV];

    centroid_frame_ctrl #(
        .IMG_W(16), .IMG_H(8), .COLOR_W(12), .THRESH('h700),
        .MIN_PIXELS(1), .ACC_W(12), .CNT_W(8)
    ) dut1 (
        .iCLK(clk), .iRST(rst1), .iColor(col1), .iDVAL(dv1), .iFVAL(fv1),
        .oX(x1), .oY(y1), .oFound(found1), .oDVAL(dval1), .oBusy(busy1),
        .oOverrun(ovr1)
    );

    centroid_frame_ctrl #(
        .IMG_W(4), .IMG_H(2), .COLOR_W(12), .THRESH('h700),
        .MIN_PIXELS(1), .ACC_W(12), .CNT_W(8)
    ) dut2 (
        .iCLK(clk), .iRST(rst2), .iColor(col2), .iDVAL(dv2), .iFVAL(fv2),
        .oX(x2), .oY(y2), .oFound(found2), .oDVAL(dval2), .oBusy(busy2),
        .oOverrun(ovr2)
    );

    always #5 clk = ~clk;

    // Count result pulses away from the active edge.
    always @(negedge clk) begin
        if (dval1) dcnt1 <= dcnt1 + 1;
        if (dval2) dcnt2 <= dcnt2 + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hp(input int x, input int y, input int c);
        return (c << 8) | (y << 4) | x;
    endfunction

    function automatic int hget(input vec_t v, input int k);
        case (k)
            0:       return v.h0;
            1:       return v.h1;
            2:       return v.h2;
            default: return v.h3;
        endcase
    endfunction

    // Full 16x8 frame from img[], with an iDVAL-low gap (bright colour) per line.
    task automatic send_frame1;
        for (int yy = 0; yy < H1; yy++) begin
            for (int xx = 0; xx < W1; xx++) begin
                dv1  = 1'b1;
                fv1  = 1'b1;
                col1 = 12'(img[yy*W1 + xx]);
                tick();
            end
            if (yy != H1 - 1) begin
                dv1  = 1'b0;
                col1 = 12'(HI);
                tick();
            end
        end
        dv1  = 1'b0;
        col1 = 12'(HI);
    endtask

    // Back-to-back 4x2 frame with a single bright pixel.
    task automatic send_frame2(input int hx, input int hy);
        for (int yy = 0; yy < H2; yy++) begin
            for (int xx = 0; xx < W2; xx++) begin
                dv2  = 1'b1;
                fv2  = 1'b1;
                col2 = (xx == hx && yy == hy) ? 12'(HI) : 12'(DARK);
                tick();
            end
        end
        dv2  = 1'b0;
        col2 = 12'(DARK);
    endtask

    // Wait (bounded) for oDVAL; latency counts the frame-end edge as 1.
    task automatic wait_dval(input int sel, input int fe_cyc,
                             output int lat, output int busy_ok);
        busy_ok = 1;
        while (!(sel == 1 ? dval1 : dval2) && (cyc - fe_cyc) < 200) begin
            if (!(sel == 1 ? busy1 : busy2)) busy_ok = 0;
            tick();
        end
        if (!(sel == 1 ? busy1 : busy2)) busy_ok = 0;
        lat = cyc - fe_cyc + 1;
    endtask

    initial begin
        int fe, lat, bok, base, h;

        vecs[0] = '{1, hp(5, 3, HI), 0, 0, 0, 5, 3, 1, 29};
        vecs[1] = '{4, hp(2, 1, HI), hp(4, 1, HI), hp(2, 5, HI), hp(4, 5, HI), 3, 3, 1, 29};
        vecs[2] = '{2, hp(1, 0, HI), hp(2, 0, HI), 0, 0, 1, 0, 1, 29};
        vecs[3] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
        vecs[4] = '{2, hp(0, 0, 'h700), hp(9, 7, 'h701), 0, 0, 9, 7, 1, 29};
        vecs[5] = '{2, hp(15, 7, HI), hp(15, 0, HI), 0, 0, 15, 3, 1, 29};

        rst1 = 1'b0; rst2 = 1'b0;
        col1 = '0;   col2 = '0;
        dv1  = 1'b0; fv1  = 1'b0;
        dv2  = 1'b0; fv2  = 1'b0;
        tick();
        tick();
        chk("reset_ox", int'(x1), 0);
        chk("reset_oy", int'(y1), 0);
        chk("reset_found", int'(found1), 0);
        chk("reset_dval", int'(dval1), 0);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_overrun", int'(ovr1), 0);
        rst1 = 1'b1; rst2 = 1'b1;
        tick();

        // Table-driven frames on the 16x8 instance.
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < W1*H1; k++) img[k] = DARK;
            for (int k = 0; k < vecs[i].n; k++) begin
                h = hget(vecs[i], k);
                img[((h >> 4) & 15) * W1 + (h & 15)] = h >> 8;
            end
            base = dcnt1;
            send_frame1();
            fe = cyc;
            wait_dval(1, fe, lat, bok);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
            chk($sformatf("v%0d_ox", i), int'(x1), vecs[i].ex);
            chk($sformatf("v%0d_oy", i), int'(y1), vecs[i].ey);
            chk($sformatf("v%0d_found", i), int'(found1), vecs[i].ef);
            chk($sformatf("v%0d_busy_during", i), bok, 1);
            tick();
            chk($sformatf("v%0d_dval_one_cycle", i), int'(dval1), 0);
            chk($sformatf("v%0d_busy_after", i), int'(busy1), 0);
            chk($sformatf("v%0d_dval_count", i), dcnt1 - base, 1);
            tick();
        end

        // Frame aborted by iFVAL after five hits, then a clean frame.
        base = dcnt1;
        for (int xx = 0; xx < 8; xx++) begin
            dv1  = 1'b1;
            fv1  = 1'b1;
            col1 = (xx < 5) ? 12'(HI) : 12'(DARK);
            tick();
        end
        dv1 = 1'b0;
        fv1 = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < W1*H1; k++) img[k] = DARK;
        img[6*W1 + 7] = HI;
        send_frame1();
        fe = cyc;
        wait_dval(1, fe, lat, bok);
        chk("abort_latency", lat, 29);
        chk("abort_ox", int'(x1), 7);
        chk("abort_oy", int'(y1), 6);
        chk("abort_found", int'(found1), 1);
        tick();
        chk("abort_dval_count", dcnt1 - base, 1);

        // Second frame end lands in DIV_X: dropped, first result intact.
        base = dcnt2;
        send_frame2(3, 1);
        fe = cyc;
        chk("ovr_first_fe_clear", int'(ovr2), 0);
        send_frame2(0, 0);
        chk("ovr_pulse", int'(ovr2), 1);
        chk("ovr_busy", int'(busy2), 1);
        tick();
        chk("ovr_pulse_one_cycle", int'(ovr2), 0);
        wait_dval(2, fe, lat, bok);
        chk("ovr_latency", lat, 29);
        chk("ovr_ox", int'(x2), 3);
        chk("ovr_oy", int'(y2), 1);
        chk("ovr_found", int'(found2), 1);
        repeat (40) tick();
        chk("ovr_dval_count", dcnt2 - base, 1);

        // Reset during DIV_Y aborts with no result and clears outputs.
        base = dcnt2;
        send_frame2(2, 0);
        repeat (20) tick();
        chk("rst_mid_busy_before", int'(busy2), 1);
        rst2 = 1'b0;
        tick();
        chk("rst_mid_ox", int'(x2), 0);
        chk("rst_mid_oy", int'(y2), 0);
        chk("rst_mid_found", int'(found2), 0);
        chk("rst_mid_busy", int'(busy2), 0);
        chk("rst_mid_dval", int'(dval2), 0);
        rst2 = 1'b1;
        repeat (40) tick();
        chk("rst_mid_no_dval", dcnt2 - base, 0);
        send_frame2(1, 1);
        fe = cyc;
        wait_dval(2, fe, lat, bok);
        chk("post_rst_latency", lat, 29);
        chk("post_rst_ox", int'(x2), 1);
        chk("post_rst_oy", int'(y2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
